// File: rtl/microsequencer.sv
// ---------------------------------------------------------------------------
// microsequencer
//
// Next-state address sequencer for the microprogrammed control unit. Holds
// the current microstate register, which addresses the microstore. Each
// cycle the sequencing fields of the returned control word, together with
// datapath status and the instruction decoder's entry state, select the next
// microstate: decode dispatch, fetch restart, absolute jump, increment,
// conditional branch or memory wait.
//
// Optional feature (compile-time macro MICROSEQ_TIMEOUT_EN):
//   When defined, a memory wait (ns_sel = 101) that holds for TIMEOUT_CYCLES
//   consecutive edges is abandoned. The sequencer recovers to INIT_STATE and
//   raises the sticky timeout flag. When undefined, a memory wait may hold
//   forever and timeout is tied to 0.
//
// Parameters:
//   STATE_W        microstate address width
//   INIT_STATE     reset / recovery microstate
//   FETCH_STATE    first microstate of the fetch sequence
//   TIMEOUT_CYCLES holding edges before forced recovery (macro build only)
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   ns_sel[2:0]    next-state mode field of the control word
//   inv            inverts the selected branch test
//   cond_sel[1:0]  branch test select: 00 moc, 01 cond, 10 one, 11 zero
//   cr_addr        absolute target field of the control word
//   decoded_state  entry microstate from the instruction decoder
//   moc            memory operation complete
//   cond           condition-tester result
//   state          registered current microstate (to microstore)
//   illegal        sticky flag: a reserved ns_sel value was executed
//   timeout        sticky flag: a memory wait timed out
// ---------------------------------------------------------------------------
module microsequencer #(
  parameter int STATE_W        = 10,
  parameter int INIT_STATE     = 0,
  parameter int FETCH_STATE    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ns_sel,
  input  logic               inv,
  input  logic [1:0]         cond_sel,
  input  logic [STATE_W-1:0] cr_addr,
  input  logic [STATE_W-1:0] decoded_state,
  input  logic               moc,
  input  logic               cond,
  output logic [STATE_W-1:0] state,
  output logic               illegal,
  output logic               timeout
);

  // Sequencing modes carried by the ns_sel field of the control word.
  typedef enum logic [2:0] {
    MODE_DECODE       = 3'b000,
    MODE_FETCH        = 3'b001,
    MODE_JUMP         = 3'b010,
    MODE_INCREMENT    = 3'b011,
    MODE_BRANCH_INC   = 3'b100,
    MODE_MEM_WAIT     = 3'b101,
    MODE_BRANCH_FETCH = 3'b110,
    MODE_RESERVED     = 3'b111
  } ns_mode_e;

  localparam logic [STATE_W-1:0] INIT_ADDR  = STATE_W'(INIT_STATE);
  localparam logic [STATE_W-1:0] FETCH_ADDR = STATE_W'(FETCH_STATE);

  ns_mode_e           mode;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [STATE_W-1:0] seq_d;
  logic [STATE_W-1:0] state_inc;
  logic               illegal_q;
  logic               illegal_d;
  logic               test_raw;
  logic               branch_t;

  assign mode      = ns_mode_e'(ns_sel);
  assign state_inc = state_q + STATE_W'(1);

  // Branch test: pick one of the status sources or a constant, then apply
  // the optional inversion. Constant 0 with inv set gives an always-taken
  // test, so both polarities of every source are reachable.
  always_comb begin
    test_raw = 1'b0;
    case (cond_sel)
      2'b00:   test_raw = moc;
      2'b01:   test_raw = cond;
      2'b10:   test_raw = 1'b1;
      default: test_raw = 1'b0;
    endcase
    branch_t = test_raw ^ inv;
  end

  // Normal sequencing decision, before any wait-timeout override. A memory
  // wait without moc simply re-selects the current state; the increment
  // wraps naturally at the register width.
  always_comb begin
    seq_d     = state_q;
    illegal_d = illegal_q;
    case (mode)
      MODE_DECODE:       seq_d = decoded_state;
      MODE_FETCH:        seq_d = FETCH_ADDR;
      MODE_JUMP:         seq_d = cr_addr;
      MODE_INCREMENT:    seq_d = state_inc;
      MODE_BRANCH_INC:   seq_d = branch_t ? cr_addr : state_inc;
      MODE_MEM_WAIT:     seq_d = moc ? state_inc : state_q;
      MODE_BRANCH_FETCH: seq_d = branch_t ? cr_addr : FETCH_ADDR;
      MODE_RESERVED: begin
        seq_d     = INIT_ADDR;
        illegal_d = 1'b1;
      end
      default:           seq_d = state_q;
    endcase
  end

`ifdef MICROSEQ_TIMEOUT_EN
  // The counter only needs to reach TIMEOUT_CYCLES-1: the edge that would
  // take it to TIMEOUT_CYCLES is the one that fires the recovery instead.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             timeout_q;
  logic             timeout_d;
  logic             holding;
  logic             expired;

  // A holding edge is a memory wait with moc low; an arriving moc takes the
  // advance path and therefore always beats the timeout. Any edge that is
  // not a holding edge restarts the count from zero.
  always_comb begin
    holding   = (mode == MODE_MEM_WAIT) && !moc;
    expired   = holding && (wait_cnt_q == CNT_LAST);
    state_d   = expired ? INIT_ADDR : seq_d;
    timeout_d = timeout_q | expired;
    if (!holding || expired) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Wait counter and sticky timeout flag; both cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign state_d = seq_d;
  assign timeout = 1'b0;
`endif

  // Microstate register and sticky illegal flag. Reset acts immediately,
  // independent of the clock, so a wedged microprogram can always be
  // recovered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT_ADDR;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_microsequencer.sv
// ---------------------------------------------------------------------------
// tb_microsequencer
//
// Self-checking bench for the microsequencer. A behavioural model tracks the
// expected microstate and flags as plain integers; a compare process checks
// the DUT against it on every falling edge, and directed steps pin the model
// with hand-computed literal values. Build with or without
// MICROSEQ_TIMEOUT_EN; the timeout expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_microsequencer;

  localparam int TB_W       = 10;
  localparam int TB_TIMEOUT = 4;
  localparam int TB_MOD     = 1 << TB_W;

  logic            clk;
  logic            reset;
  logic [2:0]      nsSel;
  logic            inv;
  logic [1:0]      condSel;
  logic [TB_W-1:0] crAddr;
  logic [TB_W-1:0] decodedState;
  logic            moc;
  logic            cond;
  logic [TB_W-1:0] state;
  logic            illegal;
  logic            timeout;

  int numChecks;
  int numFails;
  bit checkEn;

  int expState;
  bit expIllegal;
  bit expTimeout;
`ifdef MICROSEQ_TIMEOUT_EN
  int expWait;
`endif

  microsequencer #(
    .STATE_W        (TB_W),
    .INIT_STATE     (0),
    .FETCH_STATE    (1),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ns_sel        (nsSel),
    .inv           (inv),
    .cond_sel      (condSel),
    .cr_addr       (crAddr),
    .decoded_state (decodedState),
    .moc           (moc),
    .cond          (cond),
    .state         (state),
    .illegal       (illegal),
    .timeout       (timeout)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks = numChecks + 1;
    if (actual !== expected) begin
      numFails = numFails + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Model reset: recovery state, flags clear.
  function automatic void modelReset();
    expState   = 0;
    expIllegal = 1'b0;
    expTimeout = 1'b0;
`ifdef MICROSEQ_TIMEOUT_EN
    expWait    = 0;
`endif
  endfunction

  // Model of one rising edge, written from the mode table with plain
  // integer arithmetic on the currently applied inputs.
  function automatic void modelStep();
    bit t;
    int nextInc;
    case (condSel)
      2'd0:    t = moc;
      2'd1:    t = cond;
      2'd2:    t = 1'b1;
      default: t = 1'b0;
    endcase
    t       = t ^ inv;
    nextInc = (expState + 1) % TB_MOD;
    if (nsSel == 3'd5 && moc == 1'b0) begin
`ifdef MICROSEQ_TIMEOUT_EN
      expWait = expWait + 1;
      if (expWait == TB_TIMEOUT) begin
        expState   = 0;
        expTimeout = 1'b1;
        expWait    = 0;
      end
`endif
    end else begin
`ifdef MICROSEQ_TIMEOUT_EN
      expWait = 0;
`endif
      case (nsSel)
        3'd0: expState = int'(decodedState);
        3'd1: expState = 1;
        3'd2: expState = int'(crAddr);
        3'd3: expState = nextInc;
        3'd4: expState = t ? int'(crAddr) : nextInc;
        3'd5: expState = nextInc;
        3'd6: expState = t ? int'(crAddr) : 1;
        default: begin
          expState   = 0;
          expIllegal = 1'b1;
        end
      endcase
    end
  endfunction

  // Drive one microinstruction, advance the model at the rising edge and
  // return 1 ns later so literal checks see the settled state.
  task automatic applyStimulus(input logic [2:0] ns, input logic invV,
                               input logic [1:0] cs, input int cr,
                               input int dec, input logic mocV,
                               input logic condV);
    nsSel        = ns;
    inv          = invV;
    condSel      = cs;
    crAddr       = TB_W'(cr);
    decodedState = TB_W'(dec);
    moc          = mocV;
    cond         = condV;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_state", state, expState);
      checkOutput("model_illegal", illegal, expIllegal);
      checkOutput("model_timeout", timeout, expTimeout);
    end
  end

  initial begin
    numChecks    = 0;
    numFails     = 0;
    checkEn      = 1'b0;
    reset        = 1'b0;
    nsSel        = 3'd0;
    inv          = 1'b0;
    condSel      = 2'd0;
    crAddr       = '0;
    decodedState = '0;
    moc          = 1'b0;
    cond         = 1'b0;
    modelReset();

    #1 reset = 1'b1;
    #1;
    checkOutput("reset_state", state, 0);
    checkOutput("reset_illegal", illegal, 0);
    checkOutput("reset_timeout", timeout, 0);
    checkEn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_held_state", state, 0);

    // Release with the fetch word, then increment, wrap and decode.
    nsSel = 3'd1;
    reset = 1'b0;
    applyStimulus(3'd1, 0, 2'd0, 0, 0, 0, 0);
    checkOutput("fetch_after_reset", state, 1);
    applyStimulus(3'd3, 0, 2'd0, 0, 0, 0, 0);
    checkOutput("increment", state, 2);
    applyStimulus(3'd2, 0, 2'd0, 1023, 0, 0, 0);
    checkOutput("jump_1023", state, 1023);
    applyStimulus(3'd3, 0, 2'd0, 0, 0, 0, 0);
    checkOutput("increment_wrap", state, 0);
    applyStimulus(3'd0, 0, 2'd0, 0, 20, 0, 0);
    checkOutput("decode", state, 20);

    // Memory wait: hold while moc low, advance when it arrives.
    applyStimulus(3'd2, 0, 2'd0, 42, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd5, 0, 2'd0, 0, 0, 0, 0);
      checkOutput("mem_wait_hold", state, 42);
    end
    applyStimulus(3'd5, 0, 2'd0, 0, 0, 1, 0);
    checkOutput("mem_wait_advance", state, 43);

    // Branches over each test source, both polarities.
    applyStimulus(3'd4, 0, 2'd1, 40, 0, 0, 1);
    checkOutput("branch_inc_taken", state, 40);
    applyStimulus(3'd4, 1, 2'd1, 40, 0, 0, 1);
    checkOutput("branch_inc_not_taken", state, 41);
    applyStimulus(3'd6, 0, 2'd3, 40, 0, 0, 0);
    checkOutput("branch_fetch_zero", state, 1);
    applyStimulus(3'd6, 0, 2'd2, 40, 0, 0, 0);
    checkOutput("branch_fetch_one", state, 40);
    applyStimulus(3'd4, 0, 2'd0, 7, 0, 1, 0);
    checkOutput("branch_moc_taken", state, 7);
    applyStimulus(3'd4, 0, 2'd0, 7, 0, 0, 0);
    checkOutput("branch_moc_not_taken", state, 8);
    applyStimulus(3'd6, 1, 2'd1, 99, 0, 0, 0);
    checkOutput("branch_fetch_inv_cond", state, 99);

    // Wait counter restarts after any non-holding edge.
    applyStimulus(3'd2, 0, 2'd0, 60, 0, 0, 0);
    applyStimulus(3'd5, 0, 2'd0, 0, 0, 0, 0);
    applyStimulus(3'd5, 0, 2'd0, 0, 0, 0, 0);
    applyStimulus(3'd3, 0, 2'd0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(3'd5, 0, 2'd0, 0, 0, 0, 0);
      checkOutput("wait_after_clear", state, 61);
    end
    applyStimulus(3'd5, 0, 2'd0, 0, 0, 1, 0);
    checkOutput("wait_after_clear_adv", state, 62);

    // Reserved mode: recover to 0, illegal sticks.
    applyStimulus(3'd2, 0, 2'd0, 30, 0, 0, 0);
    applyStimulus(3'd7, 0, 2'd0, 0, 0, 0, 0);
    checkOutput("reserved_state", state, 0);
    checkOutput("reserved_illegal", illegal, 1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'd3, 0, 2'd0, 0, 0, 0, 0);
    end
    checkOutput("illegal_sticky", illegal, 1);
    checkOutput("after_ten_incs", state, 10);
    applyStimulus(3'd7, 0, 2'd0, 0, 0, 0, 0);
    checkOutput("reserved_again", illegal, 1);

    // Asynchronous reset between edges.
    applyStimulus(3'd2, 0, 2'd0, 23, 0, 0, 0);
    checkOutput("jump_23", state, 23);
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("async_reset_state", state, 0);
    checkOutput("async_reset_illegal", illegal, 0);
    checkOutput("async_reset_timeout", timeout, 0);
    nsSel = 3'd1;
    reset = 1'b0;
    applyStimulus(3'd1, 0, 2'd0, 0, 0, 0, 0);
    checkOutput("fetch_after_async_reset", state, 1);

    // Memory-wait timeout behaviour.
    applyStimulus(3'd2, 0, 2'd0, 50, 0, 0, 0);
`ifdef MICROSEQ_TIMEOUT_EN
    for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
      applyStimulus(3'd5, 0, 2'd0, 0, 0, 0, 0);
      checkOutput("timeout_hold", state, 50);
    end
    applyStimulus(3'd5, 0, 2'd0, 0, 0, 1, 0);
    checkOutput("timeout_advance_wins", state, 51);
    checkOutput("timeout_not_set", timeout, 0);
    for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
      applyStimulus(3'd5, 0, 2'd0, 0, 0, 0, 0);
      checkOutput("timeout_hold2", state, 51);
    end
    applyStimulus(3'd5, 0, 2'd0, 0, 0, 0, 0);
    checkOutput("timeout_state", state, 0);
    checkOutput("timeout_flag", timeout, 1);
    applyStimulus(3'd1, 0, 2'd0, 0, 0, 0, 0);
    checkOutput("timeout_sticky", timeout, 1);
`else
    for (int i = 0; i < 100; i++) begin
      applyStimulus(3'd5, 0, 2'd0, 0, 0, 0, 0);
    end
    checkOutput("no_timeout_hold", state, 50);
    checkOutput("no_timeout_flag", timeout, 0);
    applyStimulus(3'd5, 0, 2'd0, 0, 0, 1, 0);
    checkOutput("no_timeout_advance", state, 51);
`endif

    // Reset clears every sticky flag.
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("final_reset_timeout", timeout, 0);
    checkOutput("final_reset_illegal", illegal, 0);
    checkEn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             numChecks, numFails);
    $finish;
  end

endmodule
